// File: rtl/expand_tokens_if.sv
// Token stream bundle between a producer and the expand_tokens stage.
interface expand_tokens_if;
  logic a;
  logic flush;
  logic b;
  logic busy;
  logic overflow;

  modport master (
    output a,
    output flush,
    input  b,
    input  busy,
    input  overflow
  );

  modport slave (
    input  a,
    input  flush,
    output b,
    output busy,
    output overflow
  );
endinterface

// File: rtl/expand_tokens.sv
// Serial token expander: each input token becomes FACTOR output tokens via a saturating backlog.
// Optional sticky overflow flag is built only when EXPAND_TOKENS_OVERFLOW_EN is defined.
module expand_tokens #(
  parameter int FACTOR = 2,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  expand_tokens_if.slave  tok
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] MAX_S    = {2'b00, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] FACTOR_S = SUM_W'(FACTOR);
  localparam logic [SUM_W-1:0] ONE_S    = {{(SUM_W-1){1'b0}}, 1'b1};
  localparam logic [SUM_W-1:0] ZERO_S   = {SUM_W{1'b0}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic             busy_d;
  logic [SUM_W-1:0] sum_s;
  logic             b_s;
  logic             sat_s;

  // Emit whenever a token arrives or backlog remains; silent while in reset.
  assign b_s = rst & (tok.a | (cnt_q != {CNT_W{1'b0}}));

  // Backlog arithmetic carries two extra bits so the add cannot wrap and the subtract cannot go negative.
  always_comb begin
    sum_s  = {2'b00, cnt_q} + (tok.a ? FACTOR_S : ZERO_S) - (b_s ? ONE_S : ZERO_S);
    sat_s  = (sum_s > MAX_S);
    cnt_d  = sat_s ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
    busy_d = (cnt_d != {CNT_W{1'b0}});
  end

  // Backlog and busy registers; flush discards whatever is still owed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
    end else if (tok.flush) begin
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef EXPAND_TOKENS_OVERFLOW_EN
  logic overflow_q;

  // Sticky loss indication; flush takes priority over a same-cycle saturation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (tok.flush) begin
      overflow_q <= 1'b0;
    end else if (sat_s) begin
      overflow_q <= 1'b1;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign tok.overflow = overflow_q;
`else
  assign tok.overflow = 1'b0;
`endif

  assign tok.b    = b_s;
  assign tok.busy = busy_q;

endmodule

// File: doc/expand_tokens.md
# expand_tokens

Serial token expander: every `1` token sampled on `a` produces FACTOR consecutive-or-deferred `1` tokens on `b`, using a saturating backlog counter. It is the inverse of the token-halving stage in the sequential-basics set, and multiplies the token rate rather than dividing it. It sits on a single-bit token stream between a producer and a consumer with no backpressure. A flush input and an overflow indication handle the finite backlog.

## Interface

Parameters:
- `FACTOR`, default 2, output tokens per input token. Legal range 1 to 2^CNT_W.
- `CNT_W`, default 4, backlog counter width. MAX = 2^CNT_W − 1.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low. `rst == 0` at a rising edge resets the block.
- `a`  in  1  input token stream. One token per cycle with `a == 1`.
- `flush`  in  1  synchronous backlog clear.
- `b`  out  1  output token stream.
- `busy`  out  1  backlog nonzero (`cnt != 0`).
- `overflow`  out  1  sticky flag: one or more tokens were lost to saturation.

## Operation

- Internal register `cnt[CNT_W-1:0]` holds the number of pending output tokens not yet emitted.
- Output `b` is combinational: `b = rst & (a | (cnt != 0))`.
  - A token arriving on an idle block appears on `b` in the same cycle.
  - `b` is 0 while `rst == 0`.
- Per-cycle update when `rst == 1` and `flush == 0`:
  - `add = a ? FACTOR : 0`
  - `sub = b ? 1 : 0`
  - `sum = cnt + add − sub`, computed at CNT_W+2 bits and never negative.
  - If `sum <= MAX`, then `cnt <= sum`.
  - Otherwise `cnt <= MAX` (saturate) and the overflow event fires.
- Token conservation: with no saturation and no flush, the total number of `b` ones equals FACTOR × (number of `a` ones).
- Ones on `b` are contiguous while the backlog is nonzero. `b` drops to 0 in the first cycle where `cnt == 0` and `a == 0`.
- Flush (`flush == 1`, `rst == 1`):
  - `cnt <= 0` and `overflow <= 0`.
  - `b` in the flush cycle still follows the formula, including any pending `cnt`.
  - A token on `a` in the flush cycle emits exactly one `b` token; its remaining FACTOR−1 tokens are discarded.
- With `FACTOR == 1`, `cnt` stays 0 and `b == a` (pure pass-through).
- `busy = (cnt != 0)`, taken directly from the register.

## Timing

- Reset values: `cnt = 0`, `overflow = 0`, `busy = 0`, `b = 0`.
- Latency: 0 cycles from `a` to the first `b` token when idle. The remaining FACTOR−1 tokens follow on subsequent cycles, behind any existing backlog.
- `overflow` rises one cycle after the saturating edge, then stays 1 until reset or flush.
- Simultaneous flush and saturation: flush wins, so `overflow` stays 0.
- Reset mid-backlog: pending tokens are lost and `b` is 0 from the cycle `rst` goes low. No overflow is reported.
- `busy` and `overflow` are registered outputs. `b` has a combinational path from `a` and `rst`.

## Configuration

- Macro: `EXPAND_TOKENS_OVERFLOW_EN`.
- Defined: the `overflow` register and its set/clear logic are compiled in, as described above.
- Undefined:
  - `overflow` is tied to 0 and no register is built.
  - Saturation of `cnt` at MAX still occurs.
  - All other behaviour is identical.

## Test plan

All scenarios use FACTOR=2, CNT_W=4 unless stated.

- Reset: hold `rst=0` for 3 cycles with `a=1` → `b=0`, `busy=0`, `overflow=0` throughout. After release with `a=0` → `b=0`.
- Single token: `a` = 1,0,0,0 → `b` = 1,1,0,0 and `busy` = 0,1,0,0.
- Burst: `a` = 1,1,0,0,0,0 → `b` = 1,1,1,1,0,0. Across the cycles `cnt` goes 0→1→2→1→0.
- Saturation:
  - Hold `a=1` for 16 cycles, then 0 → `cnt` reaches 15 after 15 cycles. The 16th edge saturates (sum 16).
  - `overflow=1` from the next cycle and stays set.
  - `b` stays 1 for 16+15 = 31 cycles in total, not 32.
- Flush: `a` = 1,1,1,0 with `flush=1` in the 4th cycle → `b` = 1,1,1,1,0, and `cnt=0` and `busy=0` after the flush edge. Repeat with `a=1` coincident with flush → `b=1` in that cycle only, then 0.
- Pass-through and config:
  - FACTOR=1: random `a` for 200 cycles → `b == a` every cycle and `busy == 0`.
  - Build without `EXPAND_TOKENS_OVERFLOW_EN` and rerun the saturation scenario → same `b` sequence, `overflow == 0` throughout.
